uart_rx_cfg: RTL
================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver that generalises the fixed 8N1 loopback receive path. It has an integrated oversampling baud tick generator and configurable data width, parity and stop bits. It uses 3-sample majority voting per bit and a ready/valid output register with parity, framing, break and overrun detection. It sits between the board RX pin and any byte consumer: a FIFO, a command decoder or the TX side in loopback.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD, 9600, line bit rate
OVERSAMPLE, 16, ticks per bit; even, >= 8
DATA_BITS, 8, payload width; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line, idle high
rx_ready  input  1  consumer accepts the held word
rx_data  output  DATA_BITS  received payload, LSB received first
rx_valid  output  1  rx_data and flags are valid; held until accepted
parity_err  output  1  parity mismatch for the held word; 0 when PARITY=0
frame_err  output  1  a stop bit voted 0 for the held word
break_det  output  1  start, data, parity and stop bits all voted 0 for the held word
overrun  output  1  one-cycle pulse when a frame completes while rx_valid=1 and rx_ready=0

Behaviour:
- Reset (clk edge with rst=1):
  - rx_data=0, rx_valid=0, parity_err=0, frame_err=0, break_det=0, overrun=0.
  - State=IDLE; all counters 0; both synchroniser flops = 1.
- Tick generator:
  - TICK_DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division.
  - Free-running counter 0..TICK_DIV-1; tick asserted one cycle when counter = TICK_DIV-1.
  - TICK_DIV=1 gives a tick every cycle.
- Input: two-flop synchroniser; rx_s is the second flop. All decisions use rx_s only.
- Sample counter s: 0..OVERSAMPLE-1, advances on tick. Bit counter b: 0..DATA_BITS-1.
- Vote per bit: capture rx_s at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. Bit value = majority of the three. It resolves at the tick where s = OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: rx_s=0 on a tick -> START, s=0.
  - START: vote=1 -> IDLE (false start, no output). Vote=0 -> continue; at s=OVERSAMPLE-1 -> DATA.
  - DATA: voted bit shifts into bit b (LSB first). At end of bit, b=DATA_BITS-1 -> PARITY if PARITY!=0, else STOP1; otherwise b+1.
  - PARITY: even means the XOR of data and parity bit = 0; odd means it = 1. Mismatch sets the pending parity error.
  - STOP1: vote=0 sets the pending frame error.
    - STOP_BITS=2: at end of bit -> STOP2.
    - STOP_BITS=1: frame completes at the vote tick -> IDLE immediately. The second half of the stop bit is not waited for, so a back-to-back start is caught.
  - STOP2: same rule as STOP1; completes at its vote tick -> IDLE.
- Completion (cycle after the completing tick):
  - Output register empty (rx_valid=0) or being accepted this cycle (rx_ready=1): load rx_data and the three flags; rx_valid=1.
  - Otherwise: held word and flags unchanged, new frame discarded, overrun=1 for exactly one cycle.
- Handshake:
  - rx_valid=1 and rx_ready=1 at a clk edge = transfer.
  - rx_valid falls next cycle unless a completion reloads it in the same cycle, in which case rx_valid stays 1 with the new data.
  - rx_ready is ignored while rx_valid=0.
- Break: a 0-voted stop bit with all other bits 0 sets frame_err=1 and break_det=1. After the frame, the FSM returns to IDLE and re-arms only when rx_s has been 1 on at least one tick.
- Glitches: a low pulse shorter than OVERSAMPLE/2-1 ticks is rejected in START and produces no output.
- rst mid-frame: aborts the frame; no partial word is output.

Test Plan:
- Sim parameters for all scenarios: CLK_FREQ=3_200_000, BAUD=100_000, OVERSAMPLE=16 -> TICK_DIV=2, 32 clk per bit; rx_ready=1 unless stated.
- 8N1, send 0xA5 -> one completion: rx_data=0xA5, rx_valid=1, parity_err=frame_err=break_det=0; rx_valid drops the cycle after accept.
- PARITY=2, DATA_BITS=7, send 0x37 with parity bit 0 (correct value 1) -> rx_data=0x37, parity_err=1. Repeat with parity bit 1 -> parity_err=0.
- 8N1, send 0x5A with stop bit 0 -> frame_err=1, break_det=0. Hold rx=0 for 12 bit times -> rx_data=0x00, frame_err=1, break_det=1, and no further frame until rx returns high.
- rx low for 6 clk (3 ticks), then high -> FSM back to IDLE, rx_valid stays 0. Then a valid 0x3C frame is received correctly.
- rx_ready=0, send 0x11 then 0x22 back to back -> rx_data=0x11 held, overrun pulses once at the 0x22 completion. Raise rx_ready -> rx_valid falls, data 0x22 is lost.
- Assert rst for 1 clk during data bit 3 of a frame -> all outputs 0 the next cycle. The following 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled 3-sample majority voting, optional parity,
// one or two stop bits, and a ready/valid output register with error flags.
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int unsigned TICK_DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned TICK_DIV     = (TICK_DIV_RAW < 1) ? 1 : TICK_DIV_RAW;
  localparam int unsigned TW           = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW           = $clog2(OVERSAMPLE);
  localparam int unsigned BW           = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_V0   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic HAS_PAR  = (PARITY != 0);
  localparam logic ODD_PAR  = (PARITY == 1);
  localparam logic ONE_STOP = (STOP_BITS == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

  state_t               state;
  logic [TW-1:0]        tcnt;
  logic [SW-1:0]        s;
  logic [BW-1:0]        b;
  logic                 rx_m, rx_s;
  logic                 v0, v1;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, perr_p, ferr_p, stop0, armed;
  logic                 tick_c, vote_c, complete_c, ferr_c, brk_c;

  // Oversampling tick: one cycle in every TICK_DIV
  assign tick_c = (tcnt == T_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick_c) tcnt <= '0;
    else               tcnt <= tcnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Majority of the two stored samples and the live third one
  assign vote_c     = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign complete_c = tick_c && (s == S_V2) &&
                      ((state == S_STOP2) || ((state == S_STOP1) && ONE_STOP));
  assign ferr_c     = !vote_c || ((state == S_STOP2) && ferr_p);
  assign brk_c      = !vote_c && ((state == S_STOP1) || stop0) && (shreg == '0) &&
                      (!HAS_PAR || !par_bit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      s       <= '0;
      b       <= '0;
      v0      <= 1'b0;
      v1      <= 1'b0;
      shreg   <= '0;
      par_bit <= 1'b0;
      perr_p  <= 1'b0;
      ferr_p  <= 1'b0;
      stop0   <= 1'b0;
      armed   <= 1'b1;
    end else if (tick_c) begin
      if (state == S_IDLE) begin
        if (!rx_s && armed) begin
          state <= S_START;
          s     <= '0;
        end else if (rx_s) begin
          armed <= 1'b1;
        end
      end else begin
        if (s == S_V0) v0 <= rx_s;
        if (s == S_V1) v1 <= rx_s;
        s <= (s == S_END) ? '0 : s + SW'(1);
        case (state)
          S_START: begin
            if ((s == S_V2) && vote_c) begin
              state <= S_IDLE;
              s     <= '0;
            end else if (s == S_END) begin
              state  <= S_DATA;
              b      <= '0;
              perr_p <= 1'b0;
              ferr_p <= 1'b0;
            end
          end
          S_DATA: begin
            if (s == S_V2) shreg[b] <= vote_c;
            if (s == S_END) begin
              if (b == B_LAST) begin
                b     <= '0;
                state <= HAS_PAR ? S_PARITY : S_STOP1;
              end else begin
                b <= b + BW'(1);
              end
            end
          end
          S_PARITY: begin
            if (s == S_V2) begin
              par_bit <= vote_c;
              perr_p  <= ((^shreg) ^ vote_c) != ODD_PAR;
            end
            if (s == S_END) state <= S_STOP1;
          end
          S_STOP1: begin
            if (s == S_V2) begin
              ferr_p <= !vote_c;
              stop0  <= !vote_c;
            end
            if (!ONE_STOP && (s == S_END)) state <= S_STOP2;
          end
          default: ;
        endcase
        // Frame ends at the last stop vote so a back-to-back start is not missed
        if (complete_c) begin
          state <= S_IDLE;
          s     <= '0;
          if (brk_c) armed <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete_c) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          rx_valid   <= 1'b1;
          parity_err <= HAS_PAR && perr_p;
          frame_err  <= ferr_c;
          break_det  <= brk_c;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
